// File: rtl/alu_rr_arbiter.sv
// Two-port round-robin front end for a shared N-bit bitwise logic unit.
// Requesters use valid/ready handshakes. The single result register has
// backpressure, and a new result can replace a draining one in the same cycle.
module alu_rr_arbiter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [1:0]   req0_op,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [1:0]   req1_op,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic         resp_id,
    output logic [N-1:0] resp_data
);

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;

    logic         last_grant;
    logic         free;
    logic         gnt_any;
    logic         gnt_idx;
    logic         accept;
    logic [1:0]   sel_op;
    logic [N-1:0] sel_a;
    logic [N-1:0] sel_b;
    logic [N-1:0] alu_res;

    // Pure bitwise unit: no carries, so NOR covers every bit of the word.
    function automatic logic [N-1:0] alu_fn(input logic [1:0]   op,
                                            input logic [N-1:0] a,
                                            input logic [N-1:0] b);
        logic [N-1:0] r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            default: r = ~(a | b);
        endcase
        return r;
    endfunction

    // Grant selection, ready generation and operand mux. Ready depends only on
    // the valids, the slot state and last_grant, never on operands.
    always_comb begin
        free    = !resp_valid || resp_ready;
        gnt_any = req0_valid || req1_valid;
        if (req0_valid && req1_valid) begin
            gnt_idx = ~last_grant;
        end else begin
            gnt_idx = req1_valid;
        end
        req0_ready = rst_n && free && gnt_any && !gnt_idx;
        req1_ready = rst_n && free && gnt_any && gnt_idx;
        accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
        sel_op     = gnt_idx ? req1_op : req0_op;
        sel_a      = gnt_idx ? req1_a  : req0_a;
        sel_b      = gnt_idx ? req1_b  : req0_b;
        alu_res    = alu_fn(sel_op, sel_a, sel_b);
    end

    // Result register and round-robin pointer. An accept overrides a drain, so
    // a held result can be replaced on the same edge it is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_data  <= '0;
            last_grant <= 1'b1;
        end else if (accept) begin
            resp_valid <= 1'b1;
            resp_id    <= gnt_idx;
            resp_data  <= alu_res;
            last_grant <= gnt_idx;
        end else if (resp_valid && resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter. The driver pushes hand-computed results
// when it issues an operation, and the monitor pops and compares each one
// when it is consumed.
module tb_alu_rr_arbiter;

    localparam int N = 32;

    logic         clk;
    logic         rst_n;
    logic         req0_valid, req0_ready;
    logic [1:0]   req0_op;
    logic [N-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready;
    logic [1:0]   req1_op;
    logic [N-1:0] req1_a, req1_b;
    logic         resp_valid, resp_ready, resp_id;
    logic [N-1:0] resp_data;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [N:0] exp_q[$];

    alu_rr_arbiter #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_data(resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every consumed result must match the oldest expected entry.
    always @(negedge clk) begin
        if (resp_valid === 1'b1 && resp_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_resp", 32'(exp_q.size()), 32'd1);
            end else begin
                logic [N:0] e;
                e = exp_q.pop_front();
                chk("sb_resp_id", {31'd0, resp_id}, {31'd0, e[N]});
                chk("sb_resp_data", resp_data, e[N-1:0]);
            end
        end
    end

    initial begin
        rst_n = 1'b0; resp_ready = 1'b0;
        req0_valid = 1'b0; req0_op = 2'b00; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = 2'b00; req1_a = '0; req1_b = '0;

        // Reset state; ready stays low while in reset even with valid high.
        step();
        req0_valid = 1'b1;
        @(negedge clk);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_id", {31'd0, resp_id}, 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
        step();
        rst_n = 1'b1; req0_valid = 1'b0;
        step();

        // Single OR from requester 0.
        resp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 2'b01; req0_a = 32'h2; req0_b = 32'h1;
        @(negedge clk);
        chk("or_ready0", {31'd0, req0_ready}, 32'd1);
        exp_q.push_back({1'b0, 32'h3});
        step();
        req0_valid = 1'b0;
        step();

        // Full-width NOR from requester 1.
        req1_valid = 1'b1; req1_op = 2'b11; req1_a = 32'h55555555; req1_b = 32'h22222222;
        @(negedge clk);
        chk("nor_ready1", {31'd0, req1_ready}, 32'd1);
        exp_q.push_back({1'b1, 32'h88888888});
        step();
        req1_valid = 1'b0;
        step();

        // Backpressure: result held for 3 cycles, pending req1 waits.
        resp_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 2'b10; req0_a = 32'hF0F0; req0_b = 32'h0FF0;
        @(negedge clk);
        chk("bp_ready0", {31'd0, req0_ready}, 32'd1);
        exp_q.push_back({1'b0, 32'hFF00});
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_op = 2'b00; req1_a = 32'hFFFF0000; req1_b = 32'h12345678;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", {31'd0, resp_valid}, 32'd1);
            chk("bp_hold_data", resp_data, 32'hFF00);
            chk("bp_hold_id", {31'd0, resp_id}, 32'd0);
            chk("bp_hold_ready1", {31'd0, req1_ready}, 32'd0);
            step();
        end
        resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready1", {31'd0, req1_ready}, 32'd1);
        exp_q.push_back({1'b1, 32'h12340000});
        step();
        req1_valid = 1'b0;
        step();

        // Reset mid-stream while a result is held.
        resp_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 2'b01; req0_a = 32'h1; req0_b = 32'h0;
        @(negedge clk);
        chk("mid_ready0", {31'd0, req0_ready}, 32'd1);
        step();
        @(negedge clk);
        chk("mid_held_valid", {31'd0, resp_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, resp_valid}, 32'd0);
        chk("mid_rst_data", resp_data, 32'd0);
        chk("mid_rst_ready0", {31'd0, req0_ready}, 32'd0);
        step();
        rst_n = 1'b1; req0_valid = 1'b0;
        step();

        // First tie after reset goes to 0, then strict alternation.
        resp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 2'b00; req0_a = 32'h0F; req0_b = 32'h05;
        req1_valid = 1'b1; req1_op = 2'b10; req1_a = 32'hFF; req1_b = 32'h0F;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rr_ready0", {31'd0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_ready1", {31'd0, req1_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
            if (i % 2 == 0) exp_q.push_back({1'b0, 32'h05});
            else            exp_q.push_back({1'b1, 32'hF0});
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();

        // After reset, a lone req1 is granted although last_grant resets to 1.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        req1_valid = 1'b1; req1_op = 2'b01; req1_a = 32'h0F00; req1_b = 32'h00F0;
        @(negedge clk);
        chk("solo1_ready1", {31'd0, req1_ready}, 32'd1);
        chk("solo1_ready0", {31'd0, req0_ready}, 32'd0);
        exp_q.push_back({1'b1, 32'h0FF0});
        step();
        req1_valid = 1'b0;
        repeat (3) step();

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
